// File: rtl/axis_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// axis_rr_arbiter_if
// Bundles the stream signals around axis_rr_arbiter: N_SRC source-side
// AXI-Stream slave lanes and one merged AXI-Stream master lane with a tid tag.
// Signal suffixes (_i/_o) are named from the arbiter's point of view.
//   s_axis_tvalid_i / s_axis_tdata_i / s_axis_tlast_i / s_axis_tready_o
//       per-source lanes, source k data at [k*DATA_W +: DATA_W]
//   m_axis_tvalid_o / m_axis_tdata_o / m_axis_tlast_o / m_axis_tid_o /
//   m_axis_tready_i
//       merged output lane, tid = source index of the beat
// Modports:
//   slave  - the arbiter itself
//   master - the environment (sources plus downstream sink)
// ---------------------------------------------------------------------------
interface axis_rr_arbiter_if #(
    parameter int N_SRC  = 4,
    parameter int DATA_W = 8
);
    localparam int TID_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [N_SRC-1:0]        s_axis_tvalid_i;
    logic [N_SRC*DATA_W-1:0] s_axis_tdata_i;
    logic [N_SRC-1:0]        s_axis_tlast_i;
    logic [N_SRC-1:0]        s_axis_tready_o;
    logic                    m_axis_tvalid_o;
    logic [DATA_W-1:0]       m_axis_tdata_o;
    logic                    m_axis_tlast_o;
    logic [TID_W-1:0]        m_axis_tid_o;
    logic                    m_axis_tready_i;

    modport slave (
        input  s_axis_tvalid_i, s_axis_tdata_i, s_axis_tlast_i,
        output s_axis_tready_o,
        output m_axis_tvalid_o, m_axis_tdata_o, m_axis_tlast_o, m_axis_tid_o,
        input  m_axis_tready_i
    );

    modport master (
        output s_axis_tvalid_i, s_axis_tdata_i, s_axis_tlast_i,
        input  s_axis_tready_o,
        input  m_axis_tvalid_o, m_axis_tdata_o, m_axis_tlast_o, m_axis_tid_o,
        output m_axis_tready_i
    );
endinterface

// File: rtl/axis_rr_arbiter.sv
// ---------------------------------------------------------------------------
// axis_rr_arbiter
// Round-robin arbiter merging N_SRC AXI-Stream sources onto one registered
// AXI-Stream output. A grant is locked for a whole packet (until tlast), each
// output beat is tagged with its source index, and an optional watchdog frees
// the output when a granted source stalls mid-packet.
// Ports:
//   axis_aclk_i     clock
//   axis_aresetn_i  asynchronous active-low reset
//   bus             stream lanes (axis_rr_arbiter_if.slave)
//   enable_mask_i   per-source arbitration enable, looked at only in IDLE
//   grant_o         one-hot current grant, 0 while idle
//   timeout_o       sticky watchdog-release flag, cleared only by reset
// ---------------------------------------------------------------------------
module axis_rr_arbiter #(
    parameter int N_SRC       = 4,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic                axis_aclk_i,
    input  logic                axis_aresetn_i,
    axis_rr_arbiter_if.slave    bus,
    input  logic [N_SRC-1:0]    enable_mask_i,
    output logic [N_SRC-1:0]    grant_o,
    output logic                timeout_o
);
    localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    // The release fires on the idle cycle that brings the count to TIMEOUT_CYC.
    localparam logic [CNT_W-1:0] WD_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state_q,   state_d;
    logic [PTR_W-1:0]    ptr_q,     ptr_d;
    logic [N_SRC-1:0]    grant_q,   grant_d;
    logic                m_vld_q,   m_vld_d;
    logic [DATA_W-1:0]   m_data_q,  m_data_d;
    logic                m_last_q,  m_last_d;
    logic [PTR_W-1:0]    m_tid_q,   m_tid_d;
    logic [CNT_W-1:0]    wd_cnt_q,  wd_cnt_d;
    logic                timeout_q, timeout_d;

    logic [N_SRC-1:0]    s_tready;
    logic [PTR_W:0]      pick;
    logic                sel_vld;
    logic [DATA_W-1:0]   sel_data;
    logic                sel_last;
    logic                out_free;
    logic                accept;

    // Returns {found, index}: first requester after ptr, wrapping modulo N_SRC.
    // Scanning from the farthest offset down lets the nearest one win.
    function automatic logic [PTR_W:0] rr_pick(input logic [N_SRC-1:0] req,
                                               input logic [PTR_W-1:0] ptr);
        logic [PTR_W:0] idx;
        logic [PTR_W:0] res;
        res = '0;
        for (int i = N_SRC; i >= 1; i--) begin
            idx = {1'b0, ptr} + (PTR_W+1)'(i);
            if (idx >= (PTR_W+1)'(N_SRC)) idx = idx - (PTR_W+1)'(N_SRC);
            if (req[idx[PTR_W-1:0]]) res = {1'b1, idx[PTR_W-1:0]};
        end
        return res;
    endfunction

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        m_vld_d   = m_vld_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        m_tid_d   = m_tid_q;
        wd_cnt_d  = wd_cnt_q;
        timeout_d = timeout_q;
        s_tready  = '0;
        pick      = '0;
        accept    = 1'b0;
        sel_vld   = 1'b0;
        sel_data  = '0;
        sel_last  = 1'b0;

        // Constant-index mux: only the granted lane reaches the datapath,
        // so X on idle sources cannot leak into the output register.
        for (int k = 0; k < N_SRC; k++) begin
            if (ptr_q == PTR_W'(k)) begin
                sel_vld  = bus.s_axis_tvalid_i[k];
                sel_data = bus.s_axis_tdata_i[k*DATA_W +: DATA_W];
                sel_last = bus.s_axis_tlast_i[k];
            end
        end

        // Output slot is free when empty or being drained this cycle.
        out_free = ~m_vld_q | bus.m_axis_tready_i;

        if (m_vld_q && bus.m_axis_tready_i) m_vld_d = 1'b0;

        case (state_q)
            IDLE: begin
                pick = rr_pick(bus.s_axis_tvalid_i & enable_mask_i, ptr_q);
                if (pick[PTR_W]) begin
                    ptr_d    = pick[PTR_W-1:0];
                    state_d  = BUSY;
                    wd_cnt_d = '0;
                    for (int k = 0; k < N_SRC; k++)
                        grant_d[k] = (pick[PTR_W-1:0] == PTR_W'(k));
                end
            end
            BUSY: begin
                for (int k = 0; k < N_SRC; k++)
                    s_tready[k] = (ptr_q == PTR_W'(k)) & out_free;
                accept = sel_vld & out_free;
                if (accept) begin
                    m_vld_d  = 1'b1;
                    m_data_d = sel_data;
                    m_last_d = sel_last;
                    m_tid_d  = ptr_q;
                    wd_cnt_d = '0;
                    if (sel_last) begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else if (TIMEOUT_CYC > 0 && !sel_vld) begin
                    // Only cycles where the source has nothing to offer count;
                    // a downstream stall holds the count.
                    if (wd_cnt_q == WD_LAST) begin
                        state_d   = IDLE;
                        grant_d   = '0;
                        timeout_d = 1'b1;
                        wd_cnt_d  = '0;
                    end else begin
                        wd_cnt_d = wd_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i) begin
        if (!axis_aresetn_i) begin
            state_q   <= IDLE;
            ptr_q     <= PTR_W'(N_SRC - 1);
            grant_q   <= '0;
            m_vld_q   <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            m_tid_q   <= '0;
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            m_vld_q   <= m_vld_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            m_tid_q   <= m_tid_d;
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.s_axis_tready_o = s_tready;
    assign bus.m_axis_tvalid_o = m_vld_q;
    assign bus.m_axis_tdata_o  = m_data_q;
    assign bus.m_axis_tlast_o  = m_last_q;
    assign bus.m_axis_tid_o    = m_tid_q;
    assign grant_o             = grant_q;
    assign timeout_o           = timeout_q;
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Testbench for axis_rr_arbiter: a cycle table for round-robin and enable-mask
// behaviour, then hand-written sequences for packet locking, back-pressure,
// the watchdog and asynchronous reset. Output beats are matched against an
// expected-beat queue filled as stimulus is driven.
module tb_axis_rr_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 8;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  svld  = '0;
    logic [N-1:0]  slast = '0;
    logic [N-1:0]  mask  = '1;
    logic          mrdy  = 1'b1;
    logic [DW-1:0] sdata [N];
    logic [N-1:0]  grant;
    logic          tmo;

    int checks = 0;
    int errors = 0;

    typedef struct packed { logic [1:0] tid; logic [7:0] data; logic last; } beat_t;
    typedef struct packed { logic [7:0] data; logic last; } sbeat_t;
    beat_t  expq [$];
    sbeat_t srcq [N][$];
    beat_t  mon_exp;

    typedef struct {
        bit rst; logic [3:0] vld; logic [3:0] msk;
        logic [3:0] g; logic [3:0] tr; logic mv; logic [1:0] tid; logic [7:0] d;
        bit p; logic [1:0] ptid; logic [7:0] pdata;
    } vec_t;
    vec_t tbl [14];

    axis_rr_arbiter_if #(.N_SRC(N), .DATA_W(DW)) bus ();

    assign bus.s_axis_tvalid_i = svld;
    assign bus.s_axis_tlast_i  = slast;
    assign bus.s_axis_tdata_i  = {sdata[3], sdata[2], sdata[1], sdata[0]};
    assign bus.m_axis_tready_i = mrdy;

    axis_rr_arbiter #(.N_SRC(N), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .axis_aclk_i    (clk),
        .axis_aresetn_i (rst_n),
        .bus            (bus),
        .enable_mask_i  (mask),
        .grant_o        (grant),
        .timeout_o      (tmo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Output monitor: every accepted output beat must be the next expected one.
    always @(negedge clk) begin
        if (rst_n && bus.m_axis_tvalid_o && mrdy) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected: got tid=%0d data=0x%02h last=%0d, want no beat",
                         bus.m_axis_tid_o, bus.m_axis_tdata_o, bus.m_axis_tlast_o);
            end else begin
                mon_exp = expq.pop_front();
                chk("out_beat", 32'({bus.m_axis_tid_o, bus.m_axis_tdata_o, bus.m_axis_tlast_o}),
                    32'(mon_exp));
            end
        end
    end

    function automatic vec_t mk(bit rst, logic [3:0] vld, logic [3:0] msk, logic [3:0] g,
                                logic [3:0] tr, logic mv, logic [1:0] tid, logic [7:0] d,
                                bit p, logic [1:0] ptid, logic [7:0] pdata);
        vec_t v;
        v.rst = rst; v.vld = vld; v.msk = msk; v.g = g; v.tr = tr; v.mv = mv;
        v.tid = tid; v.d = d; v.p = p; v.ptid = ptid; v.pdata = pdata;
        return v;
    endfunction

    function automatic bit pending();
        bit p;
        p = (expq.size() != 0);
        for (int k = 0; k < N; k++) if (srcq[k].size() != 0) p = 1'b1;
        return p;
    endfunction

    // Called at posedge+1; returns at posedge+1 with reset released.
    task automatic do_reset();
        chk("sb_drained", 32'(expq.size()), 32'd0);
        rst_n = 1'b0;
        svld  = '0;
        slast = '0;
        mrdy  = 1'b1;
        mask  = '1;
        expq.delete();
        for (int k = 0; k < N; k++) srcq[k].delete();
        @(negedge clk);
        chk("rst_mvalid", 32'(bus.m_axis_tvalid_o), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_tready", 32'(bus.s_axis_tready_o), 32'd0);
        chk("rst_timeout", 32'(tmo), 32'd0);
        chk("rst_outregs", 32'({bus.m_axis_tid_o, bus.m_axis_tdata_o, bus.m_axis_tlast_o}), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Plays the per-source beat queues; downstream ready is low for st_len
    // cycles starting at st_at, during which the held output must be st_tid/st_data.
    // While source own still has beats, source blk must see tready low.
    task automatic run_src(input int max_cyc, input int own, input int blk,
                           input int st_at, input int st_len,
                           input logic [1:0] st_tid, input logic [7:0] st_data);
        logic [N-1:0] hs;
        int cyc;
        cyc = 0;
        while (pending() && cyc < max_cyc) begin
            for (int k = 0; k < N; k++) begin
                if (srcq[k].size() != 0) begin
                    svld[k]  = 1'b1;
                    sdata[k] = srcq[k][0].data;
                    slast[k] = srcq[k][0].last;
                end else begin
                    svld[k] = 1'b0;
                end
            end
            mrdy = !(cyc >= st_at && cyc < st_at + st_len);
            @(negedge clk);
            hs = svld & bus.s_axis_tready_o;
            if (own >= 0 && srcq[own].size() != 0)
                chk("blocked_tready", 32'(bus.s_axis_tready_o[blk]), 32'd0);
            if (!mrdy) begin
                chk("stall_mvalid", 32'(bus.m_axis_tvalid_o), 32'd1);
                chk("stall_data", 32'(bus.m_axis_tdata_o), 32'(st_data));
                chk("stall_tid", 32'(bus.m_axis_tid_o), 32'(st_tid));
                chk("stall_tready", 32'(bus.s_axis_tready_o), 32'd0);
            end
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) if (hs[k]) void'(srcq[k].pop_front());
            cyc++;
        end
        chk("drain_in_budget", 32'(pending()), 32'd0);
        svld = '0;
        mrdy = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "bench hung");
    end

    initial begin
        for (int k = 0; k < N; k++) sdata[k] = 8'(8'h10 * (k + 1));

        // Rows 0-8: src0/src2 one-beat packets; rows 9-13: enable mask gating src2.
        tbl[0]  = mk(1, 4'b0101, 4'b1111, 4'b0000, 4'b0000, 0, 0, 8'h00, 0, 0, 8'h00);
        tbl[1]  = mk(0, 4'b0101, 4'b1111, 4'b0001, 4'b0001, 0, 0, 8'h00, 1, 0, 8'h10);
        tbl[2]  = mk(0, 4'b0101, 4'b1111, 4'b0000, 4'b0000, 1, 0, 8'h10, 0, 0, 8'h00);
        tbl[3]  = mk(0, 4'b0101, 4'b1111, 4'b0100, 4'b0100, 0, 0, 8'h00, 1, 2, 8'h30);
        tbl[4]  = mk(0, 4'b0101, 4'b1111, 4'b0000, 4'b0000, 1, 2, 8'h30, 0, 0, 8'h00);
        tbl[5]  = mk(0, 4'b0101, 4'b1111, 4'b0001, 4'b0001, 0, 0, 8'h00, 1, 0, 8'h10);
        tbl[6]  = mk(0, 4'b0101, 4'b1111, 4'b0000, 4'b0000, 1, 0, 8'h10, 0, 0, 8'h00);
        tbl[7]  = mk(0, 4'b0101, 4'b1111, 4'b0100, 4'b0100, 0, 0, 8'h00, 1, 2, 8'h30);
        tbl[8]  = mk(0, 4'b0101, 4'b1111, 4'b0000, 4'b0000, 1, 2, 8'h30, 0, 0, 8'h00);
        tbl[9]  = mk(1, 4'b0100, 4'b1011, 4'b0000, 4'b0000, 0, 0, 8'h00, 0, 0, 8'h00);
        tbl[10] = mk(0, 4'b0100, 4'b1011, 4'b0000, 4'b0000, 0, 0, 8'h00, 0, 0, 8'h00);
        tbl[11] = mk(0, 4'b0100, 4'b1111, 4'b0000, 4'b0000, 0, 0, 8'h00, 0, 0, 8'h00);
        tbl[12] = mk(0, 4'b0100, 4'b1111, 4'b0100, 4'b0100, 0, 0, 8'h00, 1, 2, 8'h30);
        tbl[13] = mk(0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 1, 2, 8'h30, 0, 0, 8'h00);

        for (int i = 0; i < 14; i++) begin
            if (tbl[i].rst) do_reset();
            svld  = tbl[i].vld;
            slast = '1;
            mask  = tbl[i].msk;
            mrdy  = 1'b1;
            if (tbl[i].p) expq.push_back({tbl[i].ptid, tbl[i].pdata, 1'b1});
            @(negedge clk);
            chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(tbl[i].g));
            chk($sformatf("vec%0d_tready", i), 32'(bus.s_axis_tready_o), 32'(tbl[i].tr));
            chk($sformatf("vec%0d_mvalid", i), 32'(bus.m_axis_tvalid_o), 32'(tbl[i].mv));
            if (tbl[i].mv) begin
                chk($sformatf("vec%0d_tid", i), 32'(bus.m_axis_tid_o), 32'(tbl[i].tid));
                chk($sformatf("vec%0d_data", i), 32'(bus.m_axis_tdata_o), 32'(tbl[i].d));
            end
            @(posedge clk);
            #1;
        end

        // src1 three-beat packet is not interrupted by a waiting src3.
        do_reset();
        srcq[1].push_back({8'hA1, 1'b0});
        srcq[1].push_back({8'hA2, 1'b0});
        srcq[1].push_back({8'hA3, 1'b1});
        srcq[3].push_back({8'hD3, 1'b1});
        expq.push_back({2'd1, 8'hA1, 1'b0});
        expq.push_back({2'd1, 8'hA2, 1'b0});
        expq.push_back({2'd1, 8'hA3, 1'b1});
        expq.push_back({2'd3, 8'hD3, 1'b1});
        run_src(40, 1, 3, 0, 0, 2'd0, 8'h00);

        // Downstream stalls 5 cycles while beat 0x52 sits in the output register.
        do_reset();
        srcq[0].push_back({8'h51, 1'b0});
        srcq[0].push_back({8'h52, 1'b0});
        srcq[0].push_back({8'h53, 1'b0});
        srcq[0].push_back({8'h54, 1'b1});
        expq.push_back({2'd0, 8'h51, 1'b0});
        expq.push_back({2'd0, 8'h52, 1'b0});
        expq.push_back({2'd0, 8'h53, 1'b0});
        expq.push_back({2'd0, 8'h54, 1'b1});
        run_src(40, -1, 0, 3, 5, 2'd0, 8'h52);

        // Watchdog: src0 sends one non-last beat then goes quiet.
        do_reset();
        svld     = 4'b0001;
        sdata[0] = 8'h61;
        slast    = 4'b0000;
        expq.push_back({2'd0, 8'h61, 1'b0});
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("wd_grant_src0", 32'(grant), 32'b0001);
        chk("wd_tready_src0", 32'(bus.s_axis_tready_o), 32'b0001);
        @(posedge clk);
        #1 svld = '0;
        for (int c = 2; c <= 9; c++) begin
            if (c == 4) begin
                svld[1]  = 1'b1;
                sdata[1] = 8'h71;
                slast[1] = 1'b1;
                expq.push_back({2'd1, 8'h71, 1'b1});
            end
            @(negedge clk);
            chk($sformatf("wd_hold_grant_c%0d", c), 32'(grant), 32'b0001);
            chk($sformatf("wd_hold_timeout_c%0d", c), 32'(tmo), 32'd0);
            chk($sformatf("wd_hold_tready1_c%0d", c), 32'(bus.s_axis_tready_o[1]), 32'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("wd_release_grant", 32'(grant), 32'd0);
        chk("wd_release_timeout", 32'(tmo), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("wd_next_grant_src1", 32'(grant), 32'b0010);
        @(posedge clk);
        #1 svld = '0;
        @(negedge clk);
        chk("wd_timeout_sticky", 32'(tmo), 32'd1);
        @(posedge clk);
        #1;

        // Asynchronous reset with the output register holding a beat.
        do_reset();
        svld     = 4'b0011;
        slast    = 4'b0010;
        sdata[0] = 8'h81;
        sdata[1] = 8'h91;
        mrdy     = 1'b0;
        expq.push_back({2'd0, 8'h81, 1'b0});
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        sdata[0] = 8'h82;
        @(negedge clk);
        chk("arst_pre_mvalid", 32'(bus.m_axis_tvalid_o), 32'd1);
        chk("arst_pre_grant", 32'(grant), 32'b0001);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_mvalid", 32'(bus.m_axis_tvalid_o), 32'd0);
        chk("arst_grant", 32'(grant), 32'd0);
        chk("arst_tready", 32'(bus.s_axis_tready_o), 32'd0);
        expq.delete();
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        mrdy     = 1'b1;
        sdata[0] = 8'h81;
        expq.push_back({2'd0, 8'h81, 1'b0});
        @(negedge clk);
        chk("post_rst_idle", 32'(grant), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("post_rst_src0_first", 32'(grant), 32'b0001);
        @(posedge clk);
        #1 svld = '0;
        @(negedge clk);
        @(posedge clk);
        #1;
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
